// File: rtl/alu_cmd_master.sv
// Command master: queues ALU commands in a FIFO, issues them one at a time to an
// external combinational ALU, and returns results (with error screening) in order.
module alu_cmd_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_sel,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  op_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   wait_cnt_r;
  logic [19:0]     fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     fifo_cnt_r;

  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            push_s;
  logic            pop_s;
  logic [19:0]     head_s;
  logic            screen_err_s;
  logic [15:0]     cap_result_s;
  logic            cap_carry_s;
  logic            cap_err_s;

  assign fifo_full_s  = (fifo_cnt_r == FULL_CNT);
  assign fifo_empty_s = (fifo_cnt_r == {(AW + 1){1'b0}});
  // Ready depends only on registered occupancy so a full FIFO never bypasses.
  assign cmd_ready    = rst_n & ~fifo_full_s;
  assign push_s       = cmd_valid & cmd_ready;
  assign pop_s        = (state_r == ST_IDLE) & ~fifo_empty_s;
  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign busy         = (state_r != ST_IDLE) | ~fifo_empty_s;

  // Response screening: divide-by-zero and unused opcodes override the ALU output.
  always_comb begin
    screen_err_s = (alu_sel >= 4'hA) || ((alu_sel == 4'h3) && (alu_b == 8'h00));
    cap_result_s = 16'h0000;
    cap_carry_s  = 1'b0;
    cap_err_s    = 1'b0;
    if (screen_err_s) begin
      cap_result_s = 16'h0000;
      cap_carry_s  = 1'b0;
      cap_err_s    = 1'b1;
    end else begin
      cap_result_s = alu_result;
      cap_carry_s  = alu_carry;
      cap_err_s    = 1'b0;
    end
  end

  // Command FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 20'h00000;
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      fifo_cnt_r <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {cmd_sel, cmd_b, cmd_a};
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + (AW + 1)'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - (AW + 1)'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Issue/wait/respond sequencer with registered ALU operands and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {CW{1'b0}};
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_sel    <= 4'h0;
      rsp_valid  <= 1'b0;
      rsp_result <= 16'h0000;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            alu_sel    <= head_s[19:16];
            alu_b      <= head_s[15:8];
            alu_a      <= head_s[7:0];
            wait_cnt_r <= CNT_LOAD;
            state_r    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r != {CW{1'b0}}) begin
            wait_cnt_r <= wait_cnt_r - CW'(1);
          end else begin
            rsp_result <= cap_result_s;
            rsp_carry  <= cap_carry_s;
            rsp_err    <= cap_err_s;
            rsp_valid  <= 1'b1;
            state_r    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_master.sv
// Randomized bench for alu_cmd_master: an ALU model drives the datapath and an
// in-order expected-response array checks every response handshake.
module tb_alu_cmd_master;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  sel;
    logic [15:0] res;
    logic        c;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [3:0]  cmd_sel;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_err, busy;
  logic [7:0]  op_count;
  logic        rnd_en, rdy_dir, rdy_rand;

  logic        d3_valid, d3_ready;
  logic [7:0]  d3_cmd_a, d3_cmd_b;
  logic [3:0]  d3_cmd_sel;
  logic [7:0]  d3_alu_a, d3_alu_b;
  logic [3:0]  d3_alu_sel;
  logic [15:0] d3_alu_result;
  logic        d3_alu_carry;
  logic        d3_rsp_valid;
  logic        d3_rsp_ready;
  logic [15:0] d3_rsp_result;
  logic        d3_rsp_carry, d3_rsp_err, d3_busy;
  logic [7:0]  d3_op_count;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_arr [1024];
  int   wr_i = 0;
  int   rd_i = 0;

  assign rsp_ready = rnd_en ? rdy_rand : rdy_dir;

  alu_cmd_master #(.FIFO_DEPTH(4), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  alu_cmd_master #(.FIFO_DEPTH(4), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(d3_valid), .cmd_ready(d3_ready),
    .cmd_a(d3_cmd_a), .cmd_b(d3_cmd_b), .cmd_sel(d3_cmd_sel),
    .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_sel(d3_alu_sel),
    .alu_result(d3_alu_result), .alu_carry(d3_alu_carry),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready),
    .rsp_result(d3_rsp_result), .rsp_carry(d3_rsp_carry), .rsp_err(d3_rsp_err),
    .busy(d3_busy), .op_count(d3_op_count)
  );

  // ALU behaviour: bit 16 is the carry/borrow; garbage for undefined cases.
  function automatic logic [16:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] s);
    case (s)
      4'h0:    return 17'(a) + 17'(b);
      4'h1:    return 17'(a) - 17'(b);
      4'h2:    return 17'(a) * 17'(b);
      4'h3:    return (b != 8'h00) ? 17'(a / b) : 17'h1DEAD;
      4'h4:    return 17'(a & b);
      4'h5:    return 17'(a | b);
      4'h6:    return 17'(a ^ b);
      4'h7:    return 17'(a) << b[3:0];
      4'h8:    return 17'(a >> b[2:0]);
      4'h9:    return (b != 8'h00) ? 17'(a % b) : 17'h00000;
      default: return 17'h1BEEF;
    endcase
  endfunction

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] s);
    exp_t        e;
    logic [16:0] r;
    r = alu_f(a, b, s);
    e.a = a; e.b = b; e.sel = s;
    if (s >= 4'hA || (s == 4'h3 && b == 8'h00)) begin
      e.res = 16'h0000; e.c = 1'b0; e.e = 1'b1;
    end else begin
      e.res = r[15:0]; e.c = r[16]; e.e = 1'b0;
    end
    return e;
  endfunction

  logic [16:0] alu_r, d3_alu_r;
  always_comb alu_r = alu_f(alu_a, alu_b, alu_sel);
  always_comb d3_alu_r = alu_f(d3_alu_a, d3_alu_b, d3_alu_sel);
  assign alu_result    = alu_r[15:0];
  assign alu_carry     = alu_r[16];
  assign d3_alu_result = d3_alu_r[15:0];
  assign d3_alu_carry  = d3_alu_r[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response ready pattern for the random phase, changed away from both edges.
  initial begin
    rdy_rand = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      rdy_rand = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard: in-order response check, hold-stability check, op_count model.
  initial begin
    logic        hold_p;
    logic [17:0] held;
    logic [7:0]  cnt_m;
    exp_t        e;
    hold_p = 1'b0; held = 18'h0; cnt_m = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        rd_i = wr_i; cnt_m = 8'h00; hold_p = 1'b0;
      end else begin
        if (hold_p) begin
          chk("rsp_stable_valid", rsp_valid, 1'b1);
          chk("rsp_stable_data", {rsp_err, rsp_carry, rsp_result}, held);
        end
        if (rsp_valid && rsp_ready) begin
          chk("rsp_expected", (rd_i != wr_i), 1'b1);
          if (rd_i != wr_i) begin
            e = exp_arr[rd_i % 1024];
            rd_i++;
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_flags", {rsp_err, rsp_carry}, {e.e, e.c});
            chk("alu_hold", {alu_sel, alu_b, alu_a}, {e.sel, e.b, e.a});
          end
          chk("op_count", op_count, cnt_m);
          cnt_m = cnt_m + 8'd1;
        end
        hold_p = rsp_valid && !rsp_ready;
        held   = {rsp_err, rsp_carry, rsp_result};
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                      output int waits);
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1; waits = 0;
    while (!cmd_ready && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", cmd_ready, 1'b1);
    end else begin
      exp_arr[wr_i % 1024] = model(a, b, s);
      wr_i++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || rsp_valid || rd_i != wr_i) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n < 2000), 1'b1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, {rsp_valid, rsp_carry, rsp_err, busy, rsp_result, op_count}, 32'h0);
    chk("rst_alu_regs", {alu_sel, alu_b, alu_a}, 20'h0);
  endtask

  initial begin
    int w, n;
    logic [7:0] ra, rb;
    cmd_valid = 1'b0; cmd_a = 8'h0; cmd_b = 8'h0; cmd_sel = 4'h0;
    rnd_en = 1'b0; rdy_dir = 1'b1;
    d3_valid = 1'b0; d3_cmd_a = 8'h0; d3_cmd_b = 8'h0; d3_cmd_sel = 4'h0;
    d3_rsp_ready = 1'b1;

    @(negedge clk);
    chk("rst_cmd_ready_low", cmd_ready, 1'b0);
    chk_reset_outs("rst_outs");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk_reset_outs("rst_outs_rel");

    // Single add with latency measurement.
    send(8'd200, 8'd100, 4'h0, w);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency_lat1", n, 2);
    chk("add_result", rsp_result, 16'h012C);
    chk("add_flags", {rsp_err, rsp_carry}, 2'b00);
    wait_idle();
    chk("op_count_one", op_count, 8'd1);

    // Divide by zero, illegal opcode, then a legal divide.
    send(8'd7, 8'd0, 4'h3, w);
    send(8'd7, 8'd0, 4'hF, w);
    send(8'd20, 8'd3, 4'h3, w);
    wait_idle();

    // Backpressure: five back-to-back commands fill FIFO behind the one in flight.
    rdy_dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 9)), w);
      chk("bp_no_wait", w, 0);
    end
    chk("bp_full_ready", cmd_ready, 1'b0);
    chk("bp_busy", busy, 1'b1);
    chk("bp_rsp_valid", rsp_valid, 1'b1);
    cmd_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("bp_hold_ready", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    rdy_dir = 1'b1;
    wait_idle();
    chk("bp_op_count", op_count, 8'd9);

    // Reset while a command is in WAIT with three more queued.
    rdy_dir = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(i + 1), 8'(i + 2), 4'h0, w);
    rdy_dir = 1'b1;
    @(negedge clk);
    rdy_dir = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    chk_reset_outs("mid_rst_outs");
    @(negedge clk);
    #2 rst_n = 1'b1;
    rdy_dir = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_quiet", {rsp_valid, busy}, 2'b00);
    end

    // Random phase; 300 completions also drive op_count through its wrap.
    rnd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      send(ra, rb, 4'($urandom_range(0, 15)), w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rnd_en = 1'b0;
    wait_idle();
    chk("final_op_count", op_count, 8'(300));

    // ALU_LAT=3 instance: latency 4 edges from acceptance.
    d3_cmd_a = 8'd200; d3_cmd_b = 8'd100; d3_cmd_sel = 4'h0; d3_valid = 1'b1;
    chk("lat3_ready", d3_ready, 1'b1);
    @(negedge clk);
    d3_valid = 1'b0;
    n = 0;
    while (!d3_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency_lat3", n, 4);
    chk("lat3_result", {d3_rsp_err, d3_rsp_carry, d3_rsp_result}, 18'h0012C);
    @(negedge clk);
    chk("lat3_op_count", d3_op_count, 8'd1);
    chk("lat3_idle", {d3_rsp_valid, d3_busy}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_master.md
ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter ALU_LAT, default 1, meaning cycles (>=1) between driving ALU operands and sampling the ALU result.
REQ-003 SHALL use one clock and an asynchronous active-low reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_a in 8, cmd_b in 8, cmd_sel in 4: the command request channel.
REQ-007 SHALL have ports alu_a out 8, alu_b out 8, alu_sel out 4: operands and opcode driven to the combinational ALU.
REQ-008 SHALL have ports alu_result in 16, alu_carry in 1: ALU outputs.
REQ-009 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_result out 16, rsp_carry out 1, rsp_err out 1: the response channel.
REQ-010 SHALL have ports busy out 1 (state != IDLE or FIFO non-empty) and op_count out 8 (completed responses).

Function
REQ-011 Command accepted on a rising edge where cmd_valid && cmd_ready; {cmd_sel, cmd_b, cmd_a} written to the FIFO tail.
REQ-012 cmd_ready SHALL equal !fifo_full, with no dependence on same-cycle pop (no full-FIFO bypass).
REQ-013 FSM states: IDLE, WAIT, RESP.
REQ-014 IDLE with FIFO non-empty: pop head, register it onto alu_a/alu_b/alu_sel, load wait counter with ALU_LAT-1, go to WAIT; IDLE with FIFO empty: stay.
REQ-015 WAIT: counter > 0 -> decrement; counter == 0 -> capture response per REQ-016..018, go to RESP.
REQ-016 Capture: rsp_result <= alu_result, rsp_carry <= alu_carry, rsp_err <= 0, for alu_sel 0000..1001 except REQ-017.
REQ-017 Divide by zero (alu_sel == 0011, alu_b == 0): rsp_result <= 16'h0000, rsp_carry <= 0, rsp_err <= 1; ALU output ignored.
REQ-018 Illegal opcode (alu_sel 1010..1111): rsp_result <= 16'h0000, rsp_carry <= 0, rsp_err <= 1.
REQ-019 RESP: rsp_valid = 1; rsp_result/rsp_carry/rsp_err held stable until rsp_valid && rsp_ready; on that edge go to IDLE and increment op_count.
REQ-020 op_count SHALL wrap 255 -> 0.
REQ-021 alu_a/alu_b/alu_sel SHALL hold the in-flight command from entering WAIT until the next pop.
REQ-022 Latency: command accepted into an empty FIFO while IDLE at edge E0 -> rsp_valid high after edge E0+1+ALU_LAT.
REQ-023 Commands SHALL complete strictly in acceptance order; one in flight at a time.
REQ-024 FIFO push and pop on the same edge SHALL both take effect; occupancy unchanged.
REQ-025 Commands SHALL continue to be accepted while in WAIT or RESP until the FIFO is full.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, FIFO empty, counter 0.
REQ-027 Reset values: cmd_ready 1 (forced 0 only while rst_n low), rsp_valid 0, rsp_result 0, rsp_carry 0, rsp_err 0, alu_a 0, alu_b 0, alu_sel 0, busy 0, op_count 0.
REQ-028 Reset during WAIT or RESP SHALL drop the in-flight command and all queued commands; no response issued for them.

Verification
REQ-029 Add: cmd a=200 b=100 sel=0000, rsp_ready=1 -> rsp_valid after 2 edges (ALU_LAT=1), rsp_result=16'h012C, rsp_carry=0, rsp_err=0, op_count=1.
REQ-030 Divide by zero and illegal: a=7 b=0 sel=0011, then sel=1111 -> two responses, each rsp_result=0, rsp_err=1; then a=20 b=3 sel=0011 -> rsp_result=6, rsp_err=0.
REQ-031 Backpressure: rsp_ready=0, push 5 commands back to back -> 1 in flight, 4 queued, cmd_ready low; response stays stable; releasing rsp_ready drains all in order.
REQ-032 Reset mid-operation: assert rst_n low during WAIT with 3 queued -> all outputs at reset values, no responses after release, busy=0.
REQ-033 Wrap: complete 256 commands -> op_count returns to 0; ALU_LAT=3 build -> latency 4 edges per REQ-022.
